// File: rtl/mul_pp_sequencer.sv
// Iterative RV32M multiplier front-end: four 16x16 partial products, low-word sum via an external carry detector.
// Optional build macro MUL_EARLY_OUT_EN: a zero operand skips straight to DONE with a zero result.
module mul_pp_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    input  logic            ack_i,
    output logic [XLEN-1:0] co_a_o,
    output logic [XLEN-1:0] co_b_o,
    output logic [XLEN-1:0] co_c_o,
    output logic [XLEN-1:0] co_d_o,
    input  logic [1:0]      co_i
);

    localparam int HALF = XLEN / 2;
    localparam logic [XLEN-1:0]   ONE_X  = 1;
    localparam logic [2*XLEN-1:0] ONE_2X = 1;

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, COMB, SIGN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] magA_q, magA_d, magB_q, magB_d;
    logic [XLEN-1:0] pll_q, pll_d, plh_q, plh_d, phl_q, phl_d, phh_q, phh_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

    logic            signedA, signedB, negA, negB, zeroOp;
    logic [XLEN-1:0] absA, absB;
    logic [HALF-1:0] mulX, mulY;
    logic [XLEN-1:0] halfProd;
    logic [XLEN-1:0] coB, coC, sumLo, sumHi;
    logic [2*XLEN-1:0] negProd;

    // Operand magnitudes and result sign are fixed at accept time.
    assign signedA = (op_i == 2'b01) || (op_i == 2'b10);
    assign signedB = (op_i == 2'b01);
    assign negA    = signedA & a_i[XLEN-1];
    assign negB    = signedB & b_i[XLEN-1];
    assign absA    = negA ? (~a_i + ONE_X) : a_i;
    assign absB    = negB ? (~b_i + ONE_X) : b_i;

`ifdef MUL_EARLY_OUT_EN
    assign zeroOp = (a_i == '0) || (b_i == '0);
`else
    assign zeroOp = 1'b0;
`endif

    assign coB     = {plh_q[HALF-1:0], {HALF{1'b0}}};
    assign coC     = {phl_q[HALF-1:0], {HALF{1'b0}}};
    assign sumLo   = pll_q + coB + coC;
    assign sumHi   = phh_q + {{HALF{1'b0}}, plh_q[XLEN-1:HALF]}
                   + {{HALF{1'b0}}, phl_q[XLEN-1:HALF]}
                   + {{(XLEN-2){1'b0}}, co_i};
    assign negProd = ~{hi_q, lo_q} + ONE_2X;

    // The single half-width multiplier is shared across PP0..PP3 by steering its inputs.
    always_comb begin
        mulX = magA_q[HALF-1:0];
        mulY = magB_q[HALF-1:0];
        case (state_q)
            PP1: mulY = magB_q[XLEN-1:HALF];
            PP2: mulX = magA_q[XLEN-1:HALF];
            PP3: begin
                mulX = magA_q[XLEN-1:HALF];
                mulY = magB_q[XLEN-1:HALF];
            end
            default: ;
        endcase
        halfProd = mulX * mulY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            magA_q  <= '0;
            magB_q  <= '0;
            pll_q   <= '0;
            plh_q   <= '0;
            phl_q   <= '0;
            phh_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            magA_q  <= magA_d;
            magB_q  <= magB_d;
            pll_q   <= pll_d;
            plh_q   <= plh_d;
            phl_q   <= phl_d;
            phh_q   <= phh_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        magA_d   = magA_q;
        magB_d   = magB_q;
        pll_d    = pll_q;
        plh_d    = plh_q;
        phl_d    = phl_q;
        phh_d    = phh_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        result_o = '0;
        co_a_o   = '0;
        co_b_o   = '0;
        co_c_o   = '0;
        co_d_o   = '0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    op_d    = op_i;
                    neg_d   = negA ^ negB;
                    magA_d  = absA;
                    magB_d  = absB;
                    pll_d   = '0;
                    plh_d   = '0;
                    phl_d   = '0;
                    phh_d   = '0;
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = zeroOp ? DONE : PP0;
                end
            end
            PP0: begin
                pll_d   = halfProd;
                state_d = PP1;
            end
            PP1: begin
                plh_d   = halfProd;
                state_d = PP2;
            end
            PP2: begin
                phl_d   = halfProd;
                state_d = PP3;
            end
            PP3: begin
                phh_d   = halfProd;
                state_d = COMB;
            end
            COMB: begin
                co_a_o  = pll_q;
                co_b_o  = coB;
                co_c_o  = coC;
                lo_d    = sumLo;
                hi_d    = sumHi;
                state_d = SIGN;
            end
            SIGN: begin
                if (neg_q) begin
                    {hi_d, lo_d} = negProd;
                end
                state_d = DONE;
            end
            DONE: begin
                valid_o  = 1'b1;
                result_o = (op_q == 2'b00) ? lo_q : hi_q;
                if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
